// File: rtl/rr_arb_mux_4_1_if.sv
// ---------------------------------------------------------------------------
// rr_arb_mux_4_1_if
// Bundles the four-requester input side and the single registered output
// stage of rr_arb_mux_4_1.
//
// Signals (W = data width):
//   in_valid  [3:0]    per-requester beat valid, bit i = requester i
//   in_last   [3:0]    per-requester last-beat-of-burst flag
//   in_data   [4*W-1:0] requester i data at [i*W +: W]
//   in_ready  [3:0]    per-requester accept, one-hot or zero
//   out_valid          output stage holds a beat
//   out_ready          consumer accepts when out_valid & out_ready
//   out_data  [W-1:0]  data of the held beat
//   out_sel   [1:0]    requester index of the held beat
//   out_last           last flag of the held beat
//
// Modports:
//   slave  - the arbiter (consumes requests, drives the output stage)
//   master - the environment (drives requests, consumes the output stage)
// ---------------------------------------------------------------------------
interface rr_arb_mux_4_1_if #(
  parameter int W = 4
);
  logic [3:0]     in_valid;
  logic [3:0]     in_last;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_last;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// ---------------------------------------------------------------------------
// rr_arb_mux_4_1
// Round-robin arbiter feeding one registered 4:1 data mux. Four requesters
// offer beats with valid/ready; a multi-beat burst (terminated by last) owns
// the mux until its last beat is taken, so bursts never interleave. The
// round-robin pointer only advances at the end of a burst, to the requester
// after the one that just finished.
//
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous reset, active-high
//   bus  slave modport of rr_arb_mux_4_1_if (request side + output stage)
// ---------------------------------------------------------------------------
module rr_arb_mux_4_1 #(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_arb_mux_4_1_if.slave      bus
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t       state_r, state_nxt_s;
  logic [1:0]   ptr_r, ptr_nxt_s;
  logic [1:0]   owner_r, owner_nxt_s;

  logic         out_valid_r;
  logic [W-1:0] out_data_r;
  logic [1:0]   out_sel_r;
  logic         out_last_r;

  logic         load_s;
  logic [2:0]   pick_s;      // {found, index} of the round-robin winner
  logic [1:0]   sel_s;       // requester the mux is pointed at this cycle
  logic [3:0]   in_ready_s;
  logic         accept_s;
  logic         last_s;
  logic [W-1:0] data_s;

  // First requester with valid set, scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!res[2] && req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign load_s = !out_valid_r || bus.out_ready;
  assign pick_s = rr_pick(bus.in_valid, ptr_r);

  // Grant, handshake and next-state decode.
  always_comb begin
    in_ready_s  = 4'b0000;
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    owner_nxt_s = owner_r;
    sel_s       = owner_r;

    case (state_r)
      ST_ARB: begin
        sel_s = pick_s[1:0];
        if (pick_s[2]) begin
          in_ready_s[pick_s[1:0]] = load_s;
        end else begin
          in_ready_s = 4'b0000;
        end
      end
      ST_LOCK: begin
        // The owner keeps the mux even while idle; no one else is served.
        sel_s = owner_r;
        in_ready_s[owner_r] = load_s && bus.in_valid[owner_r];
      end
      default: begin
        sel_s       = 2'd0;
        state_nxt_s = ST_ARB;
      end
    endcase

    if (rst) begin
      in_ready_s = 4'b0000;
    end else begin
      in_ready_s = in_ready_s;
    end

    accept_s = |(bus.in_valid & in_ready_s);
    last_s   = bus.in_last[sel_s];

    if (accept_s) begin
      if (last_s) begin
        state_nxt_s = ST_ARB;
        ptr_nxt_s   = sel_s + 2'd1;
      end else begin
        state_nxt_s = ST_LOCK;
        owner_nxt_s = sel_s;
      end
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Data mux: select the granted requester's W-bit slice.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_s == 2'(i)) begin
        data_s = bus.in_data[i*W +: W];
      end else begin
        data_s = data_s;
      end
    end
  end

  // Arbitration state: FSM state, round-robin pointer and burst owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_ARB;
      ptr_r   <= 2'd0;
      owner_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      owner_r <= owner_nxt_s;
    end
  end

  // Output stage: capture an accepted beat, drain when consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= 2'd0;
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= data_s;
      out_sel_r   <= sel_s;
      out_last_r  <= last_s;
    end else if (load_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_mux_4_1
// Directed bench for rr_arb_mux_4_1: a table of per-cycle vectors (inputs,
// expected in_ready before the edge, expected output stage after the edge)
// plus hand-written sequences for reset and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_rr_arb_mux_4_1;

  localparam int W = 4;

  logic clk;
  logic rst;

  rr_arb_mux_4_1_if #(.W(W)) bus ();

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [3:0]  exp_od;
    logic [1:0]  exp_sel;
    logic        exp_ol;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [15:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [3:0] od,
                         input logic [1:0] sel, input logic ol);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(od));
    chk({tag, ".out_sel"},   32'(bus.out_sel),   32'(sel));
    chk({tag, ".out_last"},  32'(bus.out_last),  32'(ol));
  endtask

  initial begin
    // round robin, all requesters, single-beat bursts
    vt[0]  = '{4'hF, 4'hF, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0, 1'b1};
    vt[1]  = '{4'hF, 4'hF, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1, 1'b1};
    vt[2]  = '{4'hF, 4'hF, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2, 1'b1};
    vt[3]  = '{4'hF, 4'hF, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3, 1'b1};
    vt[4]  = '{4'hF, 4'hF, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0, 1'b1};
    // req1 burst 5,6,(idle),7 while req2 waits
    vt[5]  = '{4'h6, 4'h4, 16'h0E50, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1, 1'b0};
    vt[6]  = '{4'h6, 4'h4, 16'h0E60, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1, 1'b0};
    vt[7]  = '{4'h4, 4'h4, 16'h0E60, 1'b1, 4'b0000, 1'b0, 4'h6, 2'd1, 1'b0};
    vt[8]  = '{4'h6, 4'h6, 16'h0E70, 1'b1, 4'b0010, 1'b1, 4'h7, 2'd1, 1'b1};
    vt[9]  = '{4'h4, 4'h4, 16'h0E00, 1'b1, 4'b0100, 1'b1, 4'hE, 2'd2, 1'b1};
    // ptr=3: req3 (data 9) then backpressure for 3 clks, then wrap to req0
    vt[10] = '{4'h9, 4'h9, 16'h9001, 1'b1, 4'b1000, 1'b1, 4'h9, 2'd3, 1'b1};
    vt[11] = '{4'h9, 4'h9, 16'h9001, 1'b0, 4'b0000, 1'b1, 4'h9, 2'd3, 1'b1};
    vt[12] = '{4'h9, 4'h9, 16'h9001, 1'b0, 4'b0000, 1'b1, 4'h9, 2'd3, 1'b1};
    vt[13] = '{4'h9, 4'h9, 16'h9001, 1'b0, 4'b0000, 1'b1, 4'h9, 2'd3, 1'b1};
    vt[14] = '{4'h9, 4'h9, 16'h9001, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b1};
    // drain: no requests, output empties, data/sel/last hold
    vt[15] = '{4'h0, 4'h0, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0, 1'b1};
    vt[16] = '{4'h0, 4'h0, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h1, 2'd0, 1'b1};

    // Reset with every requester valid
    rst = 1'b1;
    drive(4'hF, 4'hF, 16'hDCBA, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.in_ready", 32'(bus.in_ready), 32'h0);
    chk_out("reset", 1'b0, 4'h0, 2'd0, 1'b0);
    drive(4'h0, 4'h0, 16'h0000, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle.out_valid", 32'(bus.out_valid), 32'h0);

    // Table-driven cycles
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].valid, vt[i].last, vt[i].data, vt[i].ordy);
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'(vt[i].exp_rdy));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vt[i].exp_ov, vt[i].exp_od, vt[i].exp_sel, vt[i].exp_ol);
    end

    // Reset in the middle of a req1 burst (ptr is 1 here)
    @(negedge clk);
    drive(4'h6, 4'h0, 16'h0050, 1'b1);
    #1;
    chk("mid.in_ready", 32'(bus.in_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk_out("mid.beat", 1'b1, 4'h5, 2'd1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid.rst.in_ready", 32'(bus.in_ready), 32'h0);
    chk_out("mid.rst", 1'b0, 4'h0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'h5, 4'h5, 16'h0302, 1'b1);
    #1;
    chk("post.in_ready", 32'(bus.in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk_out("post", 1'b1, 4'h2, 2'd0, 1'b1);
    @(negedge clk);
    #1;
    chk("post2.in_ready", 32'(bus.in_ready), 32'b0100);
    @(posedge clk);
    #1;
    chk_out("post2", 1'b1, 4'h3, 2'd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
